// File: rtl/pipereg_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid,
// synchronous flush, bubble flag, occupancy and a saturating stall counter.
module pipereg_skid_stage #(
  parameter int unsigned         DATA_W   = 128,
  parameter int unsigned         PC_W     = 64,
  parameter logic [PC_W-1:0]     RESET_PC = PC_W'(64'h8000_0000),
  parameter bit                  SKID     = 1'b1,
  parameter int unsigned         CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bubble,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                out_valid_q, out_bubble_q, rdy_q;
  logic [OCC_W-1:0]    occ_q;
  logic [PC_W-1:0]     main_pc_q, skid_pc_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic [CNT_W-1:0]    stall_q;
  logic                in_fire_c, out_fire_c;
  logic                load_main_in, load_main_skid, load_skid;

  // With a skid the ready is fully registered; without one it looks through
  // to out_ready. rdy_q also keeps ready low until the first edge after reset.
  assign in_ready   = SKID ? rdy_q : (rdy_q & (~out_valid_q | out_ready));
  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = out_valid_q & out_ready;

  assign out_valid    = out_valid_q;
  assign out_bubble   = out_bubble_q;
  assign out_pc       = main_pc_q;
  assign out_data     = main_data_q;
  assign occupancy    = occ_q;
  assign stall_cycles = stall_q;

  // Next-state and load-enable decode; flush overrides every other event
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_c) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire_c && out_fire_c) begin
            load_main_in = 1'b1;
          end else if (in_fire_c && SKID) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire_c) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register and the status outputs derived from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      out_bubble_q <= 1'b1;
      occ_q        <= '0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= (state_d != ST_EMPTY);
      out_bubble_q <= (state_d == ST_EMPTY);
      occ_q        <= OCC_W'(state_d);
      rdy_q        <= SKID ? (state_d != ST_FULL) : 1'b1;
    end
  end

  // Payload registers; main holds its value whenever it is not reloaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_pc_q   <= RESET_PC;
      main_data_q <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
    end else begin
      if (load_main_in) begin
        main_pc_q   <= in_pc;
        main_data_q <= in_data;
      end else if (load_main_skid) begin
        main_pc_q   <= skid_pc_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid) begin
        skid_pc_q   <= in_pc;
        skid_data_q <= in_data;
      end
    end
  end

  // Saturating count of back-pressured output cycles; survives flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule
